// File: rtl/btle_rx_pkt_decoder.sv
// BLE receive packet decoder: preamble/access-address search,
// de-whitening, header/payload octet write-out and CRC check.
`timescale 1ns/1ps
module btle_rx_pkt_decoder #(
  parameter int CRC_STATE_BIT_WIDTH      = 24,
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
  parameter int MAX_PAYLOAD_LEN          = 37
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                phy_bit,
  input  logic                                phy_bit_valid,
  input  logic [7:0]                          preamble,
  input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  access_address,
  input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
  input  logic                                crc_state_init_bit_load,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                channel_number_load,
  output logic [7:0]                          pdu_octet_mem_data,
  output logic [5:0]                          pdu_octet_mem_addr,
  output logic                                pdu_octet_mem_we,
  output logic [7:0]                          payload_length,
  output logic                                aa_detected,
  output logic                                decode_done,
  output logic                                decode_error,
  output logic                                crc_ok
);

  localparam int SW    = LEN_UNIQUE_BIT_SEQUENCE + 8;
  localparam int CW    = CRC_STATE_BIT_WIDTH;
  localparam int CHW   = CHANNEL_NUMBER_BIT_WIDTH;
  localparam int CNT_W = 11;

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CRC     = 2'd3;

  localparam logic [CW-1:0]  CRC_TAPS = CW'(24'h00065A);
  localparam logic [CW-1:0]  INIT_RST = CW'(24'h555555);
  localparam logic [CHW-1:0] CH_RST   = CHW'(37);
  localparam logic [7:0]     MAX_LEN  = 8'(MAX_PAYLOAD_LEN);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       oct_q, oct_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [6:0]       w_q, w_d;
  logic [CW-1:0]    c_q, c_d;
  logic             fail_q, fail_d;
  logic             ok_q, ok_d;
  logic             aa_q, aa_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [7:0]       data_q, data_d;
  logic [5:0]       waddr_q, waddr_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CW-1:0]    init_q, init_d;

  logic             d, fb, miss;
  logic [7:0]       oct_nx;
  logic [SW-1:0]    sreg_nx;
  logic [6:0]       w_nx;
  logic [CW-1:0]    c_nx;
  logic [CNT_W-1:0] pay_last;

  always_comb begin
    d        = phy_bit ^ w_q[6];
    fb       = c_q[CW-1] ^ d;
    miss     = d != c_q[CW-1];
    oct_nx   = {d, oct_q[7:1]};
    sreg_nx  = {phy_bit, sreg_q[SW-1:1]};
    w_nx     = {w_q[5], w_q[4], w_q[3] ^ w_q[6],
                w_q[2], w_q[1], w_q[0], w_q[6]};
    c_nx     = {c_q[CW-2:0], fb} ^ (fb ? CRC_TAPS : '0);
    pay_last = CNT_W'({len_q, 3'b000}) - CNT_W'(1);

    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    oct_d   = oct_q;
    addr_d  = addr_q;
    len_d   = len_q;
    w_d     = w_q;
    c_d     = c_q;
    fail_d  = fail_q;
    ok_d    = ok_q;
    data_d  = data_q;
    waddr_d = waddr_q;
    aa_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    ch_d    = channel_number_load ? channel_number : ch_q;
    init_d  = crc_state_init_bit_load ? crc_state_init_bit : init_q;

    if (phy_bit_valid) begin
      case (state_q)
        S_SEARCH: begin
          sreg_d = sreg_nx;
          if (sreg_nx[7:0] == preamble &&
              sreg_nx[SW-1:8] == access_address) begin
            aa_d    = 1'b1;
            state_d = S_HEADER;
            cnt_d   = '0;
            addr_d  = '0;
            ok_d    = 1'b0;
            fail_d  = 1'b0;
            w_d     = {ch_q[0], ch_q[1], ch_q[2], ch_q[3],
                       ch_q[4], ch_q[5], 1'b1};
            c_d     = init_q;
          end
        end
        S_HEADER, S_PAYLOAD: begin
          w_d   = w_nx;
          c_d   = c_nx;
          oct_d = oct_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q[2:0] == 3'd7) begin
            we_d    = 1'b1;
            data_d  = oct_nx;
            waddr_d = addr_q;
            addr_d  = addr_q + 6'd1;
          end
          if (state_q == S_HEADER && cnt_q == CNT_W'(15)) begin
            len_d = oct_nx;
            cnt_d = '0;
            if (oct_nx > MAX_LEN) begin
              err_d   = 1'b1;
              state_d = S_SEARCH;
              sreg_d  = '0;
            end else if (oct_nx == 8'd0) begin
              state_d = S_CRC;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
          if (state_q == S_PAYLOAD && cnt_q == pay_last) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end
        end
        default: begin
          // Shifting the frozen CRC walks c[23-k] into the MSB.
          w_d    = w_nx;
          c_d    = {c_q[CW-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
          fail_d = fail_q | miss;
          if (cnt_q == CNT_W'(CW - 1)) begin
            done_d  = 1'b1;
            ok_d    = ~(fail_q | miss);
            state_d = S_SEARCH;
            sreg_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_SEARCH;
      sreg_q  <= '0;
      cnt_q   <= '0;
      oct_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      w_q     <= '0;
      c_q     <= '0;
      fail_q  <= 1'b0;
      ok_q    <= 1'b0;
      aa_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      waddr_q <= '0;
      ch_q    <= CH_RST;
      init_q  <= INIT_RST;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      oct_q   <= oct_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      w_q     <= w_d;
      c_q     <= c_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
      aa_q    <= aa_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      data_q  <= data_d;
      waddr_q <= waddr_d;
      ch_q    <= ch_d;
      init_q  <= init_d;
    end
  end

  assign pdu_octet_mem_data = data_q;
  assign pdu_octet_mem_addr = waddr_q;
  assign pdu_octet_mem_we   = we_q;
  assign payload_length     = len_q;
  assign aa_detected        = aa_q;
  assign decode_done        = done_q;
  assign decode_error       = err_q;
  assign crc_ok             = ok_q;

endmodule

// File: tb/tb_btle_rx_pkt_decoder.sv
// Scoreboard bench for btle_rx_pkt_decoder: directed packets,
// expected writes/events queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_btle_rx_pkt_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phy_bit, phy_bit_valid;
  logic [7:0]  preamble;
  logic [31:0] access_address;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_bit_load;
  logic [5:0]  channel_number;
  logic        channel_number_load;
  logic [7:0]  pdu_octet_mem_data;
  logic [5:0]  pdu_octet_mem_addr;
  logic        pdu_octet_mem_we;
  logic [7:0]  payload_length;
  logic        aa_detected, decode_done, decode_error, crc_ok;

  always #5 clk = ~clk;

  btle_rx_pkt_decoder dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .phy_bit                 (phy_bit),
    .phy_bit_valid           (phy_bit_valid),
    .preamble                (preamble),
    .access_address          (access_address),
    .crc_state_init_bit      (crc_state_init_bit),
    .crc_state_init_bit_load (crc_state_init_bit_load),
    .channel_number          (channel_number),
    .channel_number_load     (channel_number_load),
    .pdu_octet_mem_data      (pdu_octet_mem_data),
    .pdu_octet_mem_addr      (pdu_octet_mem_addr),
    .pdu_octet_mem_we        (pdu_octet_mem_we),
    .payload_length          (payload_length),
    .aa_detected             (aa_detected),
    .decode_done             (decode_done),
    .decode_error            (decode_error),
    .crc_ok                  (crc_ok)
  );

  typedef struct packed {logic [5:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic ok; logic [7:0] len;} done_t;

  localparam logic [31:0] AA = 32'h8E89BED6;

  wr_t        exp_wr[$];
  done_t      exp_done[$];
  logic [7:0] exp_err[$];
  logic       exp_aa[$];
  logic [7:0] pdu[$];
  logic       tx[$];

  int n_chk = 0, n_fail = 0;
  int n_aa = 0, n_we = 0, n_done = 0, n_err = 0;
  int s_aa, s_we, s_done, s_err;
  wr_t   m_wr;
  done_t m_dn;
  logic [7:0] m_len;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pdu_octet_mem_we) begin
      n_we++;
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", 32'(pdu_octet_mem_we), 0);
      end else begin
        m_wr = exp_wr.pop_front();
        chk("wr_addr", 32'(pdu_octet_mem_addr), 32'(m_wr.a));
        chk("wr_data", 32'(pdu_octet_mem_data), 32'(m_wr.d));
      end
    end
    if (aa_detected) begin
      n_aa++;
      if (exp_aa.size() == 0)
        chk("unexpected_aa", 32'(aa_detected), 0);
      else
        void'(exp_aa.pop_front());
    end
    if (decode_done) begin
      n_done++;
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 32'(decode_done), 0);
      end else begin
        m_dn = exp_done.pop_front();
        chk("crc_ok", 32'(crc_ok), 32'(m_dn.ok));
        chk("done_len", 32'(payload_length), 32'(m_dn.len));
        chk("writes_before_done", exp_wr.size(), 0);
      end
    end
    if (decode_error) begin
      n_err++;
      if (exp_err.size() == 0) begin
        chk("unexpected_error", 32'(decode_error), 0);
      end else begin
        m_len = exp_err.pop_front();
        chk("err_len", 32'(payload_length), 32'(m_len));
        chk("writes_before_err", exp_wr.size(), 0);
      end
    end
  end

  function automatic logic [6:0] wnext(input logic [6:0] w);
    return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
  endfunction

  task automatic set_pdu(input logic [7:0] h0, input logic [7:0] h1,
                         input int n, input int base);
    pdu.delete();
    pdu.push_back(h0);
    pdu.push_back(h1);
    for (int i = 0; i < n; i++) pdu.push_back(8'(base + i * 29));
  endtask

  // Air bitstream: preamble, AA, then whitened PDU and CRC.
  task automatic build(input logic [5:0] ch, input logic [31:0] aa,
                       input int flip);
    logic [6:0]  w;
    logic [23:0] c;
    logic [7:0]  pre, by;
    logic        b, fb;
    pre = 8'hAA;
    tx.delete();
    for (int i = 0; i < 8; i++) tx.push_back(pre[i]);
    for (int i = 0; i < 32; i++) tx.push_back(aa[i]);
    w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    c = 24'h555555;
    for (int i = 0; i < pdu.size(); i++) begin
      by = pdu[i];
      for (int j = 0; j < 8; j++) begin
        b  = by[j];
        fb = c[23] ^ b;
        c  = {c[22:0], fb};
        if (fb) c = c ^ 24'h00065A;
        tx.push_back(b ^ w[6]);
        w = wnext(w);
      end
    end
    for (int k = 0; k < 24; k++) begin
      b = c[23 - k] ^ (k == flip);
      tx.push_back(b ^ w[6]);
      w = wnext(w);
    end
  endtask

  task automatic expect_writes(input int n);
    wr_t t;
    for (int i = 0; i < n; i++) begin
      t.a = 6'(i);
      t.d = pdu[i];
      exp_wr.push_back(t);
    end
  endtask

  task automatic expect_pkt(input logic ok);
    done_t t;
    exp_aa.push_back(1'b1);
    expect_writes(pdu.size());
    t.ok  = ok;
    t.len = pdu[1];
    exp_done.push_back(t);
  endtask

  task automatic send(input int from, input int to, input int maxgap);
    int gap;
    for (int i = from; i < to; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        phy_bit_valid = 1'b0;
      end
      @(negedge clk);
      phy_bit       = tx[i];
      phy_bit_valid = 1'b1;
    end
    @(negedge clk);
    phy_bit_valid = 1'b0;
  endtask

  task automatic snap();
    s_aa = n_aa; s_we = n_we; s_done = n_done; s_err = n_err;
  endtask

  task automatic counts(input string nm, input int eaa, input int ewe,
                        input int edn, input int eer);
    repeat (6) @(negedge clk);
    chk({nm, "_aa_cnt"},   n_aa - s_aa, eaa);
    chk({nm, "_we_cnt"},   n_we - s_we, ewe);
    chk({nm, "_done_cnt"}, n_done - s_done, edn);
    chk({nm, "_err_cnt"},  n_err - s_err, eer);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"},  32'(pdu_octet_mem_data), 0);
    chk({nm, "_addr"},  32'(pdu_octet_mem_addr), 0);
    chk({nm, "_we"},    32'(pdu_octet_mem_we), 0);
    chk({nm, "_len"},   32'(payload_length), 0);
    chk({nm, "_aa"},    32'(aa_detected), 0);
    chk({nm, "_done"},  32'(decode_done), 0);
    chk({nm, "_err"},   32'(decode_error), 0);
    chk({nm, "_crcok"}, 32'(crc_ok), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                   = 1'b0;
    phy_bit                 = 1'b0;
    phy_bit_valid           = 1'b0;
    preamble                = 8'hAA;
    access_address          = AA;
    crc_state_init_bit      = 24'h555555;
    crc_state_init_bit_load = 1'b0;
    channel_number          = 6'd37;
    channel_number_load     = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    set_pdu(8'h40, 8'h06, 6, 8'h17);
    build(6'd37, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 0);
    counts("good", 1, 8, 1, 0);

    build(6'd37, AA, 5);
    snap(); expect_pkt(1'b0);
    send(0, tx.size(), 0);
    counts("crcbad", 1, 8, 1, 0);

    set_pdu(8'h40, 8'h00, 0, 0);
    build(6'd37, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 0);
    counts("len0", 1, 2, 1, 0);

    set_pdu(8'h40, 8'h28, 0, 0);
    build(6'd37, AA, -1);
    snap();
    exp_aa.push_back(1'b1);
    expect_writes(2);
    exp_err.push_back(8'd40);
    send(0, tx.size(), 0);
    counts("len40", 1, 2, 0, 1);

    set_pdu(8'h40, 8'h06, 6, 8'h17);
    build(6'd37, AA ^ 32'h0000_0100, -1);
    snap();
    send(0, tx.size(), 0);
    counts("badaa", 0, 0, 0, 0);

    build(6'd37, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 5);
    counts("gaps", 1, 8, 1, 0);

    set_pdu(8'h42, 8'h25, 37, 8'h03);
    build(6'd37, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 0);
    counts("len37", 1, 39, 1, 0);

    // Abort inside payload octet 3 (4 bits into it).
    set_pdu(8'h40, 8'h06, 6, 8'h17);
    build(6'd37, AA, -1);
    snap();
    exp_aa.push_back(1'b1);
    expect_writes(5);
    send(0, 84, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    counts("midrst", 1, 5, 0, 0);
    chk("midrst_wrq", exp_wr.size(), 0);

    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 0);
    counts("postrst", 1, 8, 1, 0);

    set_pdu(8'h40, 8'h05, 5, 8'h5A);
    build(6'd37, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, 100, 0);
    channel_number      = 6'd12;
    channel_number_load = 1'b1;
    @(negedge clk);
    channel_number_load = 1'b0;
    channel_number      = 6'd37;
    send(100, tx.size(), 0);
    counts("chold", 1, 7, 1, 0);

    set_pdu(8'h40, 8'h04, 4, 8'hC1);
    build(6'd12, AA, -1);
    snap(); expect_pkt(1'b1);
    send(0, tx.size(), 0);
    counts("chnew", 1, 6, 1, 0);

    chk("final_wrq", exp_wr.size(), 0);
    chk("final_doneq", exp_done.size(), 0);
    chk("final_errq", exp_err.size(), 0);
    chk("final_aaq", exp_aa.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btle_rx_pkt_decoder.md
BTLE_RX_PKT_DECODER -- requirements
Module: btle_rx_pkt_decoder

Interface
REQ-001 SHALL have parameter CRC_STATE_BIT_WIDTH, default 24: CRC register width.
REQ-002 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6: channel index width.
REQ-003 SHALL have parameter LEN_UNIQUE_BIT_SEQUENCE, default 32: access address width.
REQ-004 SHALL have parameter MAX_PAYLOAD_LEN, default 37: largest accepted header length field, in octets.
REQ-005 SHALL have port clk, input, 1: the single clock; one clock, reset synchronous active-low.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have inputs phy_bit (1) and phy_bit_valid (1): hard-decision demodulated bit, qualified by its strobe.
REQ-008 SHALL have input preamble, 8 bits: expected preamble.
REQ-009 SHALL have input access_address, LEN_UNIQUE_BIT_SEQUENCE bits: expected access address.
REQ-010 SHALL have inputs crc_state_init_bit (CRC_STATE_BIT_WIDTH) and crc_state_init_bit_load (1): CRC init value and its load strobe.
REQ-011 SHALL have inputs channel_number (CHANNEL_NUMBER_BIT_WIDTH) and channel_number_load (1): de-whitening seed and its load strobe.
REQ-012 SHALL have outputs pdu_octet_mem_data (8), pdu_octet_mem_addr (6) and pdu_octet_mem_we (1): write port for de-whitened header and payload octets.
REQ-013 SHALL have output payload_length, 8 bits: the header length field.
REQ-014 SHALL have outputs aa_detected, decode_done and decode_error (1 bit each, pulses), and crc_ok (1 bit, level).

Function
REQ-015 SHALL track the following states:
- SEARCH
- HEADER
- PAYLOAD
- CRC

REQ-016 SHALL update all state only on cycles with phy_bit_valid=1; gaps of any length are tolerated.

REQ-017 SEARCH: 40-bit shift register.
- On each valid bit, the register shifts right and the new bit enters bit 39.
- Match condition: sreg[7:0]==preamble and sreg[39:8]==access_address, exact match with no error tolerance.

REQ-018 On a match:
- aa_detected pulses one cycle after the matching bit.
- State goes to HEADER.
- Bit and octet counters clear.
- crc_ok clears.
- The de-whitening LFSR and CRC register load from the latched channel and CRC init values.

REQ-019 The *_load strobes latch their values in any state; a latched value is used from the next AA match onward, and a packet in flight is not disturbed.

REQ-020 De-whitening uses a 7-bit register w[6:0].
- Init: w0=1, w1=ch[5], w2=ch[4], w3=ch[3], w4=ch[2], w5=ch[1], w6=ch[0].
- Per bit: d = phy_bit ^ w6.
- Update: w0<=w6, w4<=w3^w6, and every other wi<=w(i-1).

REQ-021 CRC uses register c[23:0], initialised to the latched init value.
- Per de-whitened header or payload bit: fb = c23^d.
- Update: c <= {c[22:0],fb}, XORed with fb into bits 1, 3, 4, 6, 9 and 10.

REQ-022 Octet assembly is LSB-first.
- The 8th bit of each octet produces pdu_octet_mem_we=1 for one cycle on the following cycle.
- Write address starts at 0 and increments per octet.

REQ-023 HEADER covers 16 bits.
- The second octet is captured into payload_length.
- If payload_length>MAX_PAYLOAD_LEN: decode_error pulses, state returns to SEARCH, sreg clears, no decode_done.
- Else, if payload_length==0: state goes to CRC.
- Else: state goes to PAYLOAD.

REQ-024 PAYLOAD covers payload_length×8 bits, then state goes to CRC.

REQ-025 CRC covers 24 de-whitened bits, which are not written to memory.
- The k-th received bit (k=0..23) is compared against c[23-k], where c is frozen at CRC entry.
- Any mismatch marks a failure.

REQ-026 After the 24th CRC bit:
- decode_done pulses next cycle, with crc_ok valid in that same cycle.
- crc_ok holds until the next aa_detected or reset.
- State returns to SEARCH with sreg cleared.

REQ-027 A new preamble/AA pattern arriving during HEADER, PAYLOAD or CRC is ignored.

REQ-028 Address never wraps: the maximum write address is MAX_PAYLOAD_LEN+1, which is 38 at the default and fits 6 bits.

Reset
REQ-029 When rst_n=0 at a clock edge, the following SHALL become 0: all outputs, state (=SEARCH), sreg, counters and payload_length.

REQ-030 On reset, latched channel resets to 37 and latched CRC init resets to 0x555555.

REQ-031 Reset mid-packet aborts the packet with no decode_done and no decode_error, and the decoder resumes search after rst_n=1.

Verification
REQ-032 Setup ch=37, AA=0x8E89BED6, preamble=0xAA, init=0x555555. Stimulus: whitened bitstream of an 8-octet PDU (header 0x40,0x06) with valid CRC. Required response: aa_detected once, 8 writes at addr 0..7 matching the PDU, payload_length=6, decode_done with crc_ok=1.

REQ-033 Stimulus: same stream with CRC bit 5 inverted. Required response: identical writes, decode_done, crc_ok=0.

REQ-034 Stimulus: header length=0. Required response: exactly 2 writes, then decode_done with crc_ok=1 after 24 further bits. Stimulus: length=40. Required response: decode_error after the 16th header bit, no decode_done.

REQ-035 Stimulus: AA with one bit flipped. Required response: no aa_detected. Stimulus: random bit_valid gaps (0–5 idle cycles) on the REQ-032 stream. Required response: identical outputs.

REQ-036 Stimulus: rst_n=0 during payload octet 3. Required response: all outputs 0, no done or error; a following clean packet decodes with crc_ok=1.

REQ-037 Stimulus: channel_number_load=1 with ch=12 mid-packet. Required response: current packet still de-whitens with ch 37, and the next packet uses ch 12.
